// File: rtl/pll_seq.sv
// PLL bring-up sequencer: settle with enable low, wait for lock with bounded
// retries, monitor lock in LOCKED (filtered loss detect), relock on divider change.
module pll_seq #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT  = 64,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned LOSS_FILTER   = 3
) (
  input  logic       rclk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] fbdiv_in,
  input  logic       lock,
  output logic       en,
  output logic [7:0] fbdiv,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    WAIT_LOCK = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } state_e;

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]  LOSS_LAST    = 8'(LOSS_FILTER - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [7:0]  fbdiv_q, fbdiv_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  filt_q, filt_d;
  logic [7:0]  fbdiv_map;

  // A zero divider is never legal on the core, so it is promoted to 1.
  assign fbdiv_map = (fbdiv_in == 8'd0) ? 8'd1 : fbdiv_in;

  always_comb begin
    state_d  = state_q;
    fbdiv_d  = fbdiv_q;
    retry_d  = retry_q;
    loss_d   = loss_q;
    settle_d = settle_q;
    timer_d  = timer_q;
    filt_d   = filt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          fbdiv_d = fbdiv_map;
          retry_d = 4'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!req)                       state_d = IDLE;
        else if (settle_q == SETTLE_LAST) state_d = WAIT_LOCK;
        else                            settle_d = settle_q + 8'd1;
      end
      WAIT_LOCK: begin
        if (!req)      state_d = IDLE;
        else if (lock) state_d = LOCKED;
        else if (timer_q == TIMEOUT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = SETTLE;
          end else begin
            state_d = FAIL;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      LOCKED: begin
        if (!req) begin
          state_d = IDLE;
        end else if (fbdiv_map != fbdiv_q) begin
          fbdiv_d = fbdiv_map;
          state_d = SETTLE;
        end else if (lock) begin
          filt_d = 8'd0;
        end else if (filt_q == LOSS_LAST) begin
          if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
          retry_d = 4'd0;
          state_d = SETTLE;
        end else begin
          filt_d = filt_q + 8'd1;
        end
      end
      FAIL: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every state entry starts its counters from zero.
    if (state_d != state_q) begin
      settle_d = 8'd0;
      timer_d  = 16'd0;
      filt_d   = 8'd0;
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      fbdiv_q  <= 8'd1;
      retry_q  <= 4'd0;
      loss_q   <= 8'd0;
      settle_q <= 8'd0;
      timer_q  <= 16'd0;
      filt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      fbdiv_q  <= fbdiv_d;
      retry_q  <= retry_d;
      loss_q   <= loss_d;
      settle_q <= settle_d;
      timer_q  <= timer_d;
      filt_q   <= filt_d;
    end
  end

  // Outputs decode straight from the state flop, so rst drops en immediately.
  assign en        = (state_q == WAIT_LOCK) || (state_q == LOCKED);
  assign ready     = (state_q == LOCKED);
  assign fail      = (state_q == FAIL);
  assign fbdiv     = fbdiv_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_seq.sv
// Directed bench for pll_seq with default parameters; inputs change and
// outputs are sampled on the falling edge of rclk.
module tb_pll_seq;
  logic       rclk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] fbdiv_in;
  logic       lock;
  logic       en;
  logic [7:0] fbdiv;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  pll_seq dut (
    .rclk(rclk), .rst(rst), .req(req), .fbdiv_in(fbdiv_in), .lock(lock),
    .en(en), .fbdiv(fbdiv), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
  );

  always #5 rclk = ~rclk;

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  // Drive a request and wait (bounded) for WAIT_LOCK, then raise lock.
  task automatic bring_up(input logic [7:0] fb);
    req = 1'b1; fbdiv_in = fb; lock = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (state == 3'd2) break;
    end
    lock = 1'b1;
    tick(1);
    tests++;
    if (state !== 3'd3) begin
      fails++;
      $display("FAIL bring_up_locked: state=%0d expected=3", state);
    end
  endtask

  task automatic test_reset;
    tests++;
    if ({state, en, fbdiv, ready, fail, retry_cnt, loss_cnt} !==
        {3'd0, 1'b0, 8'd1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_values: state=%0d en=%b fbdiv=%0d ready=%b fail=%b retry=%0d loss=%0d",
               state, en, fbdiv, ready, fail, retry_cnt, loss_cnt);
    end
  endtask

  task automatic test_nominal;
    int settle_n;
    settle_n = 0;
    req = 1'b1; fbdiv_in = 8'd8; lock = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (en) break;
      if (state == 3'd1) settle_n++;
    end
    tests++;
    if (settle_n !== 4 || en !== 1'b1 || fbdiv !== 8'd8) begin
      fails++;
      $display("FAIL nominal_settle: settle_cycles=%0d en=%b fbdiv=%0d expected 4/1/8", settle_n, en, fbdiv);
    end
    tick(19);
    tests++;
    if (state !== 3'd2 || ready !== 1'b0) begin
      fails++;
      $display("FAIL nominal_waiting: state=%0d ready=%b expected 2/0", state, ready);
    end
    lock = 1'b1;
    tick(1);
    tests++;
    if (ready !== 1'b1 || state !== 3'd3 || retry_cnt !== 4'd0 || en !== 1'b1) begin
      fails++;
      $display("FAIL nominal_locked: ready=%b state=%0d retry=%0d en=%b expected 1/3/0/1",
               ready, state, retry_cnt, en);
    end
    req = 1'b0; lock = 1'b0;
    tick(1);
  endtask

  task automatic test_retry_fail;
    int en_bad, rt_bad, exp_en;
    logic [3:0] exp_rt;
    en_bad = 0; rt_bad = 0;
    req = 1'b1; fbdiv_in = 8'd8; lock = 1'b0;
    for (int i = 0; i < 210; i++) begin
      tick(1);
      exp_en = ((i >= 4 && i < 68) || (i >= 72 && i < 136) || (i >= 140 && i < 204)) ? 1 : 0;
      exp_rt = (i < 68) ? 4'd0 : (i < 136) ? 4'd1 : 4'd2;
      if (en !== exp_en[0]) en_bad++;
      if (retry_cnt !== exp_rt) rt_bad++;
    end
    tests++;
    if (en_bad != 0) begin
      fails++;
      $display("FAIL retry_en_windows: %0d cycles with wrong en", en_bad);
    end
    tests++;
    if (rt_bad != 0) begin
      fails++;
      $display("FAIL retry_cnt_sequence: %0d cycles with wrong retry_cnt", rt_bad);
    end
    tests++;
    if (fail !== 1'b1 || en !== 1'b0 || state !== 3'd4) begin
      fails++;
      $display("FAIL retry_final: fail=%b en=%b state=%0d expected 1/0/4", fail, en, state);
    end
    req = 1'b0;
    tick(1);
    tests++;
    if (state !== 3'd0 || fail !== 1'b0) begin
      fails++;
      $display("FAIL fail_exit: state=%0d fail=%b expected 0/0", state, fail);
    end
  endtask

  task automatic test_loss;
    int settle_n;
    bring_up(8'd8);
    lock = 1'b0;
    tick(2);
    lock = 1'b1;
    tick(1);
    tests++;
    if (state !== 3'd3 || loss_cnt !== 8'd0) begin
      fails++;
      $display("FAIL loss_glitch2: state=%0d loss=%0d expected 3/0", state, loss_cnt);
    end
    lock = 1'b0;
    tick(2);
    tests++;
    if (state !== 3'd3) begin
      fails++;
      $display("FAIL loss_pending: state=%0d expected 3", state);
    end
    tick(1);
    tests++;
    if (state !== 3'd1 || loss_cnt !== 8'd1 || en !== 1'b0 || retry_cnt !== 4'd0) begin
      fails++;
      $display("FAIL loss_event: state=%0d loss=%0d en=%b retry=%0d expected 1/1/0/0",
               state, loss_cnt, en, retry_cnt);
    end
    settle_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (state != 3'd1) break;
      settle_n++;
    end
    tests++;
    if (settle_n !== 4 || state !== 3'd2 || en !== 1'b1) begin
      fails++;
      $display("FAIL loss_resettle: settle_cycles=%0d state=%0d en=%b expected 4/2/1", settle_n, state, en);
    end
    req = 1'b0;
    tick(1);
  endtask

  task automatic test_divider;
    bring_up(8'd8);
    fbdiv_in = 8'd16;
    tick(1);
    tests++;
    if (state !== 3'd1 || fbdiv !== 8'd16 || loss_cnt !== 8'd1) begin
      fails++;
      $display("FAIL div_change: state=%0d fbdiv=%0d loss=%0d expected 1/16/1", state, fbdiv, loss_cnt);
    end
    req = 1'b0; lock = 1'b0;
    tick(1);
    tests++;
    if (state !== 3'd0 || fbdiv !== 8'd16 || loss_cnt !== 8'd1) begin
      fails++;
      $display("FAIL div_retain: state=%0d fbdiv=%0d loss=%0d expected 0/16/1", state, fbdiv, loss_cnt);
    end
    fbdiv_in = 8'd0; req = 1'b1;
    tick(1);
    tests++;
    if (fbdiv !== 8'd1 || state !== 3'd1) begin
      fails++;
      $display("FAIL div_zero_map: fbdiv=%0d state=%0d expected 1/1", fbdiv, state);
    end
    fbdiv_in = 8'd5;
    tick(1);
    tests++;
    if (fbdiv !== 8'd1) begin
      fails++;
      $display("FAIL div_ignored_settle: fbdiv=%0d expected 1", fbdiv);
    end
    for (int i = 0; i < 10; i++) begin
      if (state == 3'd2) break;
      tick(1);
    end
    lock = 1'b1;
    tick(1);
    tests++;
    if (state !== 3'd3 || fbdiv !== 8'd1) begin
      fails++;
      $display("FAIL div_locked_old: state=%0d fbdiv=%0d expected 3/1", state, fbdiv);
    end
    tick(1);
    tests++;
    if (state !== 3'd1 || fbdiv !== 8'd5) begin
      fails++;
      $display("FAIL div_relock: state=%0d fbdiv=%0d expected 1/5", state, fbdiv);
    end
    req = 1'b0; lock = 1'b0;
    tick(1);
  endtask

  task automatic test_abort;
    req = 1'b1; fbdiv_in = 8'd8; lock = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (state == 3'd2) break;
    end
    tick(3);
    req = 1'b0;
    tick(1);
    tests++;
    if (state !== 3'd0 || en !== 1'b0 || fbdiv !== 8'd8) begin
      fails++;
      $display("FAIL abort_wait: state=%0d en=%b fbdiv=%0d expected 0/0/8", state, en, fbdiv);
    end
  endtask

  task automatic test_async_reset;
    bring_up(8'd9);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({state, en, fbdiv, ready, fail, retry_cnt, loss_cnt} !==
        {3'd0, 1'b0, 8'd1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      fails++;
      $display("FAIL async_reset: state=%0d en=%b fbdiv=%0d ready=%b fail=%b retry=%0d loss=%0d",
               state, en, fbdiv, ready, fail, retry_cnt, loss_cnt);
    end
    req = 1'b0; lock = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    tests++;
    if (state !== 3'd0) begin
      fails++;
      $display("FAIL reset_release_idle: state=%0d expected 0", state);
    end
    req = 1'b1; fbdiv_in = 8'd3;
    tick(1);
    tests++;
    if (state !== 3'd1 || fbdiv !== 8'd3) begin
      fails++;
      $display("FAIL reset_release_start: state=%0d fbdiv=%0d expected 1/3", state, fbdiv);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; fbdiv_in = 8'd0; lock = 1'b0;
    tick(2);
    test_reset;
    rst = 1'b0;
    tick(1);
    test_nominal;
    test_retry_fail;
    test_loss;
    test_divider;
    test_abort;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
